floating_point_add_sub_pipe: RTL and testbench

Parametrised, 4-stage pipelined IEEE-754-style floating-point adder/subtractor with valid/ready flow control, the successor to the combinational single-precision adder. It accepts two operands plus an add/subtract select each cycle, aligns, adds, normalises and rounds them, and returns a result with status flags. Exponent and mantissa widths are parameters, so one block covers half, single and double precision. It sits between the operand-issue logic and the FPU result bus.

---
 rtl/floating_point_add_sub_pipe.sv | 247 ++++++++++++++++++++++++
 tb/tb_floating_point_add_sub_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/floating_point_add_sub_pipe.sv
// 4-stage pipelined FP add/sub (unpack, align, add, normalise/round); FP_ADD_RNE_EN selects RNE, else truncate.
// Latency 4 cycles, 1/cycle; a held result (valid_out & ~ready_in) freezes every stage and drops ready_out.
module floating_point_add_sub_pipe #(
  parameter int EXPO_WIDTH = 8,
  parameter int MENT_WIDTH = 23
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [EXPO_WIDTH+MENT_WIDTH:0] floating1_in,
  input  logic [EXPO_WIDTH+MENT_WIDTH:0] floating2_in,
  input  logic                           op_sub_in,
  input  logic                           valid_in,
  output logic                           ready_out,
  output logic [EXPO_WIDTH+MENT_WIDTH:0] result_out,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic [3:0]                     flags_out
);
  localparam int E          = EXPO_WIDTH;
  localparam int M          = MENT_WIDTH;
  localparam int DATA_WIDTH = 1 + E + M;
  localparam int SW         = M + 4;
  localparam int LW         = $clog2(SW + 1);
  localparam int EW         = ((E > LW) ? E : LW) + 2;

  localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
  localparam logic signed [EW-1:0]  EMAX = EW'((1 << E) - 1);

  typedef struct packed {
    logic                  sign;
    logic [E-1:0]          exp;
    logic [M:0]            big_sig;
    logic [M:0]            small_sig;
    logic [E-1:0]          diff;
    logic                  eff_sub;
    logic                  spec;
    logic [DATA_WIDTH-1:0] spec_res;
    logic [3:0]            spec_flags;
  } s1_t;

  typedef struct packed {
    logic                  sign;
    logic [E-1:0]          exp;
    logic [SW-1:0]         big_ext;
    logic [SW-1:0]         small_al;
    logic                  eff_sub;
    logic                  spec;
    logic [DATA_WIDTH-1:0] spec_res;
    logic [3:0]            spec_flags;
  } s2_t;

  typedef struct packed {
    logic                  sign;
    logic [E-1:0]          exp;
    logic [SW:0]           sum;
    logic                  spec;
    logic [DATA_WIDTH-1:0] spec_res;
    logic [3:0]            spec_flags;
  } s3_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic v1_q, v2_q, v3_q;
  logic adv;

  assign adv       = ~valid_out | ready_in;
  assign ready_out = adv;

  // S1: unpack, classify, order by magnitude
  logic         sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, a_big, inf_clash;
  logic [E-1:0] ea, eb;
  logic [M-1:0] ma, mb;

  always_comb begin
    sa        = floating1_in[DATA_WIDTH-1];
    sb        = floating2_in[DATA_WIDTH-1] ^ op_sub_in;
    ea        = floating1_in[M +: E];
    eb        = floating2_in[M +: E];
    za        = (ea == '0);
    zb        = (eb == '0);
    ma        = za ? '0 : floating1_in[M-1:0];
    mb        = zb ? '0 : floating2_in[M-1:0];
    nan_a     = (ea == '1) && (ma != '0);
    nan_b     = (eb == '1) && (mb != '0);
    inf_a     = (ea == '1) && (ma == '0);
    inf_b     = (eb == '1) && (mb == '0);
    inf_clash = inf_a & inf_b & (sa ^ sb);
    a_big     = {ea, ma} >= {eb, mb};

    s1_d         = '0;
    s1_d.eff_sub = sa ^ sb;
    if (a_big) begin
      s1_d.sign      = sa;
      s1_d.exp       = ea;
      s1_d.big_sig   = {~za, ma};
      s1_d.small_sig = {~zb, mb};
      s1_d.diff      = ea - eb;
    end else begin
      s1_d.sign      = sb;
      s1_d.exp       = eb;
      s1_d.big_sig   = {~zb, mb};
      s1_d.small_sig = {~za, ma};
      s1_d.diff      = eb - ea;
    end

    if (nan_a | nan_b | inf_clash) begin
      s1_d.spec       = 1'b1;
      s1_d.spec_res   = QNAN;
      s1_d.spec_flags = {inf_clash | (nan_a & ~ma[M-1]) | (nan_b & ~mb[M-1]), 3'b000};
    end else if (inf_a | inf_b) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {(inf_a ? sa : sb), {E{1'b1}}, {M{1'b0}}};
    end else if (za & zb) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {sa & sb, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  // S2: align small operand, collapsing shifted-out bits into sticky
  logic [SW-1:0] small_ext, lost_mask;

  always_comb begin
    small_ext       = {s1_q.small_sig, 3'b000};
    lost_mask       = ~({SW{1'b1}} << s1_q.diff);
    s2_d            = '0;
    s2_d.sign       = s1_q.sign;
    s2_d.exp        = s1_q.exp;
    s2_d.big_ext    = {s1_q.big_sig, 3'b000};
    s2_d.eff_sub    = s1_q.eff_sub;
    s2_d.spec       = s1_q.spec;
    s2_d.spec_res   = s1_q.spec_res;
    s2_d.spec_flags = s1_q.spec_flags;
    if (32'(s1_q.diff) >= M + 3) begin
      s2_d.small_al = {{(SW-1){1'b0}}, |s1_q.small_sig};
    end else begin
      s2_d.small_al    = small_ext >> s1_q.diff;
      s2_d.small_al[0] = s2_d.small_al[0] | (|(small_ext & lost_mask));
    end
  end

  // S3: magnitude add/subtract; big >= small so the difference is never negative
  always_comb begin
    s3_d            = '0;
    s3_d.exp        = s2_q.exp;
    s3_d.spec       = s2_q.spec;
    s3_d.spec_res   = s2_q.spec_res;
    s3_d.spec_flags = s2_q.spec_flags;
    if (s2_q.eff_sub)
      s3_d.sum = {1'b0, s2_q.big_ext} - {1'b0, s2_q.small_al};
    else
      s3_d.sum = {1'b0, s2_q.big_ext} + {1'b0, s2_q.small_al};
    s3_d.sign = (s3_d.sum == '0) ? 1'b0 : s2_q.sign;
  end

  // S4: normalise, round, range-check, apply special override
  function automatic logic [LW-1:0] lzc(input logic [SW-1:0] v);
    logic [LW-1:0] n;
    n = LW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) n = LW'(SW - 1 - i);
    return n;
  endfunction

  logic [LW-1:0]          lz;
  logic [SW-1:0]          norm;
  logic signed [EW-1:0]   exp_n, exp_r;
  logic [M+1:0]           rnd;
  logic [M-1:0]           mant;
  logic                   g, r, s, inc;
  logic [DATA_WIDTH-1:0]  res_d;
  logic [3:0]             flags_d;

  always_comb begin
    lz = lzc(s3_q.sum[SW-1:0]);
    if (s3_q.sum[SW]) begin
      norm  = {s3_q.sum[SW:2], s3_q.sum[1] | s3_q.sum[0]};
      exp_n = EW'(s3_q.exp) + EW'(1);
    end else begin
      norm  = s3_q.sum[SW-1:0] << lz;
      exp_n = EW'(s3_q.exp) - EW'(lz);
    end
    g = norm[2];
    r = norm[1];
    s = norm[0];
`ifdef FP_ADD_RNE_EN
    inc = g & (r | s | norm[3]);
`else
    inc = 1'b0;
`endif
    rnd = {1'b0, norm[SW-1:3]} + (M+2)'(inc);
    if (rnd[M+1]) begin
      mant  = rnd[M:1];
      exp_r = exp_n + EW'(1);
    end else begin
      mant  = rnd[M-1:0];
      exp_r = exp_n;
    end

    res_d   = '0;
    flags_d = '0;
    if (s3_q.spec) begin
      res_d   = s3_q.spec_res;
      flags_d = s3_q.spec_flags;
    end else if (s3_q.sum == '0) begin
      res_d = '0;
    end else if (exp_r >= EMAX) begin
`ifdef FP_ADD_RNE_EN
      res_d = {s3_q.sign, {E{1'b1}}, {M{1'b0}}};
`else
      res_d = {s3_q.sign, E'((1 << E) - 2), {M{1'b1}}};
`endif
      flags_d = 4'b0101;
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      res_d   = {s3_q.sign, {(DATA_WIDTH-1){1'b0}}};
      flags_d = 4'b0011;
    end else begin
      res_d   = {s3_q.sign, exp_r[E-1:0], mant};
      flags_d = {3'b000, g | r | s};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      valid_out  <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      result_out <= '0;
      flags_out  <= '0;
    end else if (adv) begin
      v1_q       <= valid_in;
      v2_q       <= v1_q;
      v3_q       <= v2_q;
      valid_out  <= v3_q;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      result_out <= res_d;
      flags_out  <= flags_d;
    end
  end

endmodule

// File: tb/tb_floating_point_add_sub_pipe.sv
// Directed bench for floating_point_add_sub_pipe: single precision plus a half-precision instance.
module tb_floating_point_add_sub_pipe;
`ifdef FP_ADD_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f1, f2, res;
  logic        sub, vin, rdy_out, vout, rdy_in;
  logic [3:0]  flags;
  logic [15:0] h_f1, h_f2, h_res;
  logic        h_sub, h_vin, h_rdy_out, h_vout, h_rdy_in;
  logic [3:0]  h_flags;

  int checks   = 0;
  int failures = 0;

  logic [31:0] vals [0:9] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                              32'h41100000, 32'h41200000};

  always #5 clk = ~clk;

  floating_point_add_sub_pipe dut (
    .clk_in(clk), .rst_n_in(rst_n), .floating1_in(f1), .floating2_in(f2),
    .op_sub_in(sub), .valid_in(vin), .ready_out(rdy_out), .result_out(res),
    .valid_out(vout), .ready_in(rdy_in), .flags_out(flags)
  );

  floating_point_add_sub_pipe #(.EXPO_WIDTH(5), .MENT_WIDTH(10)) dut_h (
    .clk_in(clk), .rst_n_in(rst_n), .floating1_in(h_f1), .floating2_in(h_f2),
    .op_sub_in(h_sub), .valid_in(h_vin), .ready_out(h_rdy_out), .result_out(h_res),
    .valid_out(h_vout), .ready_in(h_rdy_in), .flags_out(h_flags)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b, input logic op,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    if (half) begin
      h_f1 = a[15:0]; h_f2 = b[15:0]; h_sub = op; h_vin = 1'b1;
    end else begin
      f1 = a; f2 = b; sub = op; vin = 1'b1;
    end
    @(posedge clk); #1;
    h_vin = 1'b0;
    vin   = 1'b0;
    lat   = 1;
    while (!(half ? h_vout : vout) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = half ? {16'h0, h_res} : res;
    f = half ? h_flags : flags;
  endtask

  task automatic test_op(input string tag, input bit half, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] er, input logic [3:0] ef);
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    run_op(half, a, b, op, r, f, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_res"}, 64'(r), 64'(er));
    chk({tag, "_flg"}, 64'(f), 64'(ef));
  endtask

  initial begin
    int sent, got, cyc;
    rst_n = 1'b0;
    f1 = '0; f2 = '0; sub = 1'b0; vin = 1'b0; rdy_in = 1'b1;
    h_f1 = '0; h_f2 = '0; h_sub = 1'b0; h_vin = 1'b0; h_rdy_in = 1'b1;

    #12;
    chk("rst_vld", 64'(vout), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_flg", 64'(flags), 64'd0);
    chk("rst_h_vld", 64'(h_vout), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", 64'(rdy_out), 64'd1);
    chk("rst_h_rdy", 64'(h_rdy_out), 64'd1);

    test_op("add_1p2",   0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    test_op("sub_eq",    0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    test_op("sub_neg",   0, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
    test_op("inf_inf",   0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    test_op("qnan",      0, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    test_op("snan",      0, 32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000);
    test_op("inf_fin",   0, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
    test_op("nzero",     0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    test_op("ovf",       0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RNE ? 32'h7F800000 : 32'h7F7FFFFF, 4'b0101);
    test_op("tie_even",  0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    test_op("tie_odd",   0, 32'h3F800001, 32'h33800000, 1'b0, RNE ? 32'h3F800002 : 32'h3F800001, 4'b0001);
    test_op("unf",       0, 32'h80800001, 32'h00800000, 1'b0, 32'h80000000, 4'b0011);
    test_op("h_add",     1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, 4'b0000);
    test_op("h_ovf",     1, 32'h7BFF, 32'h7BFF, 1'b0, RNE ? 32'h7C00 : 32'h7BFF, 4'b0101);

    // Streaming with random backpressure: results must pop in order, held stable while stalled
    sent = 0; got = 0; cyc = 0;
    while ((sent < 8 || got < 8) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      rdy_in = 1'($urandom_range(0, 1));
      vin    = (sent < 8);
      if (sent < 8) begin
        f1 = vals[sent]; f2 = vals[0]; sub = 1'b0;
      end
      #1;
      if (vin && rdy_out) sent++;
      if (vout && rdy_in) begin
        chk("stream_res", 64'(res), 64'(got < 8 ? vals[got+1] : 32'hFFFFFFFF));
        chk("stream_flg", 64'(flags), 64'd0);
        got++;
      end else if (vout) begin
        chk("stall_rdy", 64'(rdy_out), 64'd0);
        @(negedge clk);
        chk("stall_vld", 64'(vout), 64'd1);
        chk("stall_res", 64'(res), 64'(got < 8 ? vals[got+1] : 32'hFFFFFFFF));
        #1;
        if (vin && rdy_out) sent++;
        if (vout && rdy_in) begin
          chk("stream_res", 64'(res), 64'(got < 8 ? vals[got+1] : 32'hFFFFFFFF));
          got++;
        end
      end
    end
    vin = 1'b0;
    rdy_in = 1'b1;
    chk("stream_sent", 64'(sent), 64'd8);
    chk("stream_got", 64'(got), 64'd8);
    repeat (6) @(posedge clk);
    #1;
    chk("stream_drain", 64'(vout), 64'd0);

    // Reset pulsed with the pipeline full
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vin = 1'b1; f1 = vals[i]; f2 = vals[0]; sub = 1'b0;
    end
    @(negedge clk);
    vin = 1'b0;
    chk("prerst_vld", 64'(vout), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 64'(vout), 64'd0);
    chk("midrst_res", 64'(res), 64'd0);
    chk("midrst_flg", 64'(flags), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_rdy", 64'(rdy_out), 64'd1);
    chk("postrst_vld", 64'(vout), 64'd0);
    test_op("postrst", 0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    @(posedge clk); #1;
    chk("postrst_idle", 64'(vout), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
